// File: rtl/reg_file_pkg.sv
// Shared register-file types: default widths, address type and zero index.
// Imported by the register file, scoreboard, ALU and operand mux blocks.
package reg_file_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/reg_file_sb_sb_bank.sv
// Busy-bit scoreboard: reserve sets, write clears, reserve wins on a tie.
// Query outputs show the post-update busy state; error flag is sticky.
module sb_bank
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NQ       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rsv_en,
  input  logic [ADDR_W-1:0]  rsv_addr,
  input  logic               clr_en,
  input  logic [ADDR_W-1:0]  clr_addr,
  input  logic [NQ*ADDR_W-1:0] q_addr,
  output logic [NQ-1:0]      q_busy,
  output logic               sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             r_err;
  logic             w_rsv_ok;
  logic             w_clr_ok;
  logic             w_same;
  logic             w_waw;
  logic             w_nores;

  assign w_rsv_ok = rsv_en && !(ZR && rsv_addr == ZA);
  assign w_clr_ok = clr_en && !(ZR && clr_addr == ZA);
  assign w_same   = (rsv_addr == clr_addr);

  assign w_waw   = w_rsv_ok && r_busy[rsv_addr]
                && !(w_clr_ok && w_same);
  assign w_nores = w_clr_ok && !r_busy[clr_addr]
                && !(w_rsv_ok && w_same);

  // Set after clear so a same-address reserve keeps the new producer pending
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr_ok) w_busy_nxt[clr_addr] = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_waw || w_nores) r_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NQ; k++) begin : g_q
    assign q_busy[k] = w_busy_nxt[q_addr[k*ADDR_W +: ADDR_W]];
  end

  assign sb_err = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-first read ports, zero register
// and a per-register busy scoreboard; every output is flopped.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NREAD      = 2,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic                    sb_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit II = (INIT_INDEX != 0);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [NREAD*DATA_W-1:0] r_rd_data;
  logic [NREAD*DATA_W-1:0] w_rd_data;
  logic [NREAD-1:0]        r_rd_busy;
  logic [NREAD-1:0]        w_q_busy;
  logic                    w_wr_ok;

  assign w_wr_ok = wr_en && !(ZR && wr_addr == ZA);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= II ? DATA_W'(i) : '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_byp;

    assign w_ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero = ZR && (w_ra == ZA);
    assign w_byp  = w_wr_ok && (wr_addr == w_ra);

    // w_byp never fires for the zero register, so the arms are exclusive
    assign w_rd_data[k*DATA_W +: DATA_W] =
      w_zero ? '0 :
      w_byp  ? wr_data :
               r_mem[w_ra];
  end

  sb_bank #(
    .ADDR_W   (ADDR_W),
    .NQ       (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .q_addr   (rd_addr),
    .q_busy   (w_q_busy),
    .sb_err   (sb_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      r_rd_data <= w_rd_data;
      r_rd_busy <= w_q_busy;
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table on the default build,
// an INIT_INDEX=0 build, and a randomized 4-port 16x8 build vs a model.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // default build
  logic        a_rst = 1'b0;
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en = 1'b0;
  logic [4:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_rsv_en = 1'b0;
  logic [4:0]  a_rsv_addr = '0;
  logic        a_err;

  reg_file_sb u_a (
    .clk(clk), .rst(a_rst),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .sb_err(a_err)
  );

  // INIT_INDEX=0 build
  logic        b_rst = 1'b0;
  logic [9:0]  b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic        b_err;

  reg_file_sb #(.INIT_INDEX(0)) u_b (
    .clk(clk), .rst(b_rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy),
    .wr_en(1'b0), .wr_addr(5'd0),
    .wr_data(32'd0),
    .rsv_en(1'b0), .rsv_addr(5'd0),
    .sb_err(b_err)
  );

  // sweep build
  logic        s_rst = 1'b0;
  logic [11:0] s_rd_addr = '0;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic        s_wr_en = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic        s_rsv_en = 1'b0;
  logic [2:0]  s_rsv_addr = '0;
  logic        s_err;

  reg_file_sb #(
    .DATA_W(16), .ADDR_W(3), .NREAD(4)
  ) u_s (
    .clk(clk), .rst(s_rst),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .sb_err(s_err)
  );

  typedef struct {
    bit rst;
    bit we; int wa; int wd;
    bit re; int ra;
    int r0; int r1;
    int d0; int d1;
    bit b0; bit b1; bit err;
  } vec_t;

  vec_t v[$];

  // reference model for the sweep build
  logic [15:0] m_mem [8];
  bit          m_busy [8];
  bit          m_err;

  function automatic int pick(bit want_busy);
    int s = $urandom_range(0, 7);
    for (int j = 0; j < 8; j++) begin
      int a = (s + j) % 8;
      if (a != 0 && m_busy[a] == want_busy) return a;
    end
    return s;
  endfunction

  task automatic s_step(bit rst, bit we, int wa, int wd,
                        bit re, int ra, logic [11:0] rds);
    logic [15:0] ed [4];
    bit          eb [4];
    s_rst = rst; s_wr_en = we;
    s_wr_addr = 3'(wa); s_wr_data = 16'(wd);
    s_rsv_en = re; s_rsv_addr = 3'(ra);
    s_rd_addr = rds;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i] = 16'(i);
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
      for (int k = 0; k < 4; k++) begin
        ed[k] = '0;
        eb[k] = 1'b0;
      end
    end else begin
      if (re && ra != 0 && m_busy[ra] && !(we && wa == ra))
        m_err = 1'b1;
      if (we && wa != 0 && !m_busy[wa] && !(re && ra == wa))
        m_err = 1'b1;
      if (we && wa != 0) m_mem[wa] = 16'(wd);
      if (we) m_busy[wa] = 1'b0;
      if (re && ra != 0) m_busy[ra] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        int a = int'(rds[k*3 +: 3]);
        ed[k] = m_mem[a];
        eb[k] = m_busy[a];
      end
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s_data%0d", k),
          32'(s_rd_data[k*16 +: 16]), 32'(ed[k]));
      chk($sformatf("s_busy%0d", k),
          32'(s_rd_busy[k]), 32'(eb[k]));
    end
    chk("s_err", 32'(s_err), 32'(m_err));
  endtask

  initial begin
    // rst we wa wd re ra r0 r1 d0 d1 b0 b1 err
    v.push_back('{1,0,0,0,0,0, 3,31, 0,0, 0,0,0});
    v.push_back('{0,0,0,0,0,0, 3,31, 3,31, 0,0,0});
    v.push_back('{0,0,0,0,1,5, 5,0, 5,0, 1,0,0});
    v.push_back('{0,1,5,-2000,0,0, 5,0, -2000,0, 0,0,0});
    v.push_back('{0,1,0,1300,0,0, 0,5, 0,-2000, 0,0,0});
    v.push_back('{0,0,0,0,0,0, 0,0, 0,0, 0,0,0});
    v.push_back('{0,0,0,0,1,7, 7,3, 7,3, 1,0,0});
    v.push_back('{0,1,7,42,0,0, 7,7, 42,42, 0,0,0});
    v.push_back('{0,0,0,0,1,7, 7,3, 42,3, 1,0,0});
    v.push_back('{0,1,7,99,1,7, 7,7, 99,99, 1,1,0});
    v.push_back('{0,1,7,100,0,0, 7,5, 100,-2000, 0,0,0});
    v.push_back('{0,0,0,0,1,0, 0,7, 0,100, 0,0,0});
    v.push_back('{0,0,0,0,1,9, 9,9, 9,9, 1,1,0});
    v.push_back('{0,0,0,0,1,9, 9,0, 9,0, 1,0,1});
    v.push_back('{0,0,0,0,0,0, 9,0, 9,0, 1,0,1});
    v.push_back('{1,1,4,77,1,4, 9,4, 0,0, 0,0,0});
    v.push_back('{0,0,0,0,0,0, 9,4, 9,4, 0,0,0});
    v.push_back('{0,1,10,5,0,0, 10,0, 5,0, 0,0,1});
    v.push_back('{1,0,0,0,0,0, 10,0, 0,0, 0,0,0});
    v.push_back('{0,0,0,0,0,0, 10,31, 10,31, 0,0,0});
    v.push_back('{0,1,12,555,1,12, 12,12, 555,555, 1,1,0});
    v.push_back('{0,1,12,556,1,13, 12,13, 556,13, 0,1,0});
    v.push_back('{0,1,13,-1,1,13, 13,31, -1,31, 1,0,0});
    v.push_back('{0,1,13,8,0,0, 13,13, 8,8, 0,0,0});
    v.push_back('{0,0,0,0,0,0, 13,0, 8,0, 0,0,0});

    for (int i = 0; i < v.size(); i++) begin
      a_rst = v[i].rst;
      a_wr_en = v[i].we;
      a_wr_addr = 5'(v[i].wa);
      a_wr_data = 32'(v[i].wd);
      a_rsv_en = v[i].re;
      a_rsv_addr = 5'(v[i].ra);
      a_rd_addr = {5'(v[i].r1), 5'(v[i].r0)};
      tick();
      chk($sformatf("a_d0[%0d]", i),
          a_rd_data[31:0], 32'(v[i].d0));
      chk($sformatf("a_d1[%0d]", i),
          a_rd_data[63:32], 32'(v[i].d1));
      chk($sformatf("a_b0[%0d]", i),
          32'(a_rd_busy[0]), 32'(v[i].b0));
      chk($sformatf("a_b1[%0d]", i),
          32'(a_rd_busy[1]), 32'(v[i].b1));
      chk($sformatf("a_err[%0d]", i),
          32'(a_err), 32'(v[i].err));
    end
    a_rst = 1'b0; a_wr_en = 1'b0; a_rsv_en = 1'b0;

    // INIT_INDEX=0: every register resets to zero
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    b_rd_addr = {5'd31, 5'd3};
    tick();
    chk("b_d0", b_rd_data[31:0], 32'd0);
    chk("b_d1", b_rd_data[63:32], 32'd0);
    chk("b_busy", 32'(b_rd_busy), 32'd0);
    chk("b_err", 32'(b_err), 32'd0);

    // randomized sweep against the model
    s_step(1, 0, 0, 0, 0, 0, 12'd0);
    for (int c = 0; c < 600; c++) begin
      bit rst = ($urandom_range(0, 49) == 0);
      bit we  = 1'($urandom_range(0, 1));
      bit re  = 1'($urandom_range(0, 1));
      int wa  = ($urandom_range(0, 3) != 0)
              ? pick(1'b1) : $urandom_range(0, 7);
      int ra  = ($urandom_range(0, 3) != 0)
              ? pick(1'b0) : $urandom_range(0, 7);
      int wd  = $urandom_range(0, 65535);
      s_step(rst, we, wa, wd, re, ra, 12'($urandom));
    end

    // reserve several registers, then reset mid-sequence
    s_step(1, 0, 0, 0, 0, 0, 12'd0);
    for (int r = 1; r <= 4; r++)
      s_step(0, 0, 0, 0, 1, r, {3'(r), 3'(r), 3'(r), 3'(r)});
    s_step(1, 0, 0, 0, 0, 0, 12'd0);
    s_step(0, 0, 0, 0, 0, 0, {3'd4, 3'd3, 3'd2, 3'd1});
    chk("s_rst_busy_lo", 32'(s_rd_busy), 32'd0);
    s_step(0, 0, 0, 0, 0, 0, {3'd0, 3'd7, 3'd6, 3'd5});
    chk("s_rst_busy_hi", 32'(s_rd_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, scoreboarded register file for the datapath; replaces the fixed 32×32, two-read-port register file. Provides `NREAD` registered read ports with write-first bypass, one write port, a hardwired zero register, and a per-register busy scoreboard so issue logic can detect pending writes (RAW/WAW) without a separate structure. Sits between decode (read/reserve) and writeback (write), feeding the ALU operand muxes.

## Interface
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, address width; depth is `2**ADDR_W`.
- `NREAD`, 2, number of read ports, from 1 to 4.
- `ZERO_REG`, 1, register 0 hardwired to zero when 1.
- `INIT_INDEX`, 1, reset loads register i with value i when 1, or 0 when 0.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rd_addr` in `NREAD*ADDR_W`: read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `rd_data` out `NREAD*DATA_W`: registered read data, signed two's complement.
- `rd_busy` out `NREAD`: registered busy flag of each read address.
- `wr_en` in 1: write enable.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in `DATA_W`: write data.
- `rsv_en` in 1: reserve, which marks `rsv_addr` as pending-write.
- `rsv_addr` in `ADDR_W`: reserved destination.
- `sb_err` out 1: sticky scoreboard error flag; cleared only by `rst`.

## Operation
- **Storage:** `2**ADDR_W` × `DATA_W` array.
  - Reset: register i = `INIT_INDEX ? i[DATA_W-1:0] : 0`. Values of i wider than `DATA_W` truncate.
  - Register 0 resets to 0 whenever `ZERO_REG=1`.
- **Write:** when `wr_en` is high, `wr_addr` is loaded with `wr_data`.
  - With `ZERO_REG=1`, writes to address 0 are dropped silently.
- **Read port k:** captures `mem[rd_addr_k]` each cycle.
  - Write-first bypass: if `wr_en && wr_addr==rd_addr_k` in the same cycle (and the write is not dropped), `rd_data_k` takes `wr_data`.
  - Address 0 with `ZERO_REG=1` always returns 0.
- **Scoreboard:** one busy bit per register, all 0 after reset.
  - `rsv_en` sets `busy[rsv_addr]`.
  - `wr_en` clears `busy[wr_addr]`.
  - Same address, same cycle: reserve wins, so busy=1 (the new producer is pending).
  - Different addresses: both updates apply.
  - With `ZERO_REG=1`, `busy[0]` is constant 0 and a reserve of address 0 is ignored.
- **Read busy:** `rd_busy_k` captures the busy bit after the same-edge updates (set/clear-first, same as data).
- **Error conditions** set `sb_err` on the next edge; it stays set until `rst`:
  - (a) `rsv_en` to an address already busy that is not being cleared this cycle (WAW with a pending producer).
  - (b) `wr_en` to an address whose busy is 0 and which is not being reserved this cycle (write with no reservation).
  - Address 0 with `ZERO_REG=1` never flags.
  - On an error, storage and busy still update per the rules above.

## Timing
- **Read latency:** 1 cycle. Address presented before edge N gives data valid after edge N and reflects any write at edge N.
- **Write latency:** 1 cycle. Data is visible to reads sampled at the same edge via the bypass, and in the array from edge N+1.
- **Reserve latency:** 1 cycle. A read of that address at the same edge reports busy=1.
- **Reset:** `rst` high at an edge takes precedence over every enable.
  - Array reinitialises; all busy bits, `rd_data`, `rd_busy` and `sb_err` go to 0.
  - `rst` applied mid-sequence discards pending reservations.
- **Combinational paths:** none from inputs to outputs; all outputs are flopped.

## Structure
- **Package `reg_file_pkg`:** default `DATA_W`/`ADDR_W` localparams, a `reg_addr_t` typedef, and `ZERO_ADDR`. Shared with the ALU and mux blocks.
- **Sub-module `sb_bank`:** the busy-bit vector plus error detection. Inputs are reserve/clear enables and addresses, a query address vector, and `ZERO_REG`. Outputs are query busy bits and `sb_err`.
- **`reg_file_sb`:** holds the array, bypass muxes and output flops.

## Test plan
- **Reset:** assert `rst` 1 cycle, then read addresses 3 and 31 → `rd_data` = 3 and 31, `rd_busy` = 0, `sb_err` = 0. With `INIT_INDEX=0`, both read 0.
- **Bypass:** `wr_en`=1, `wr_addr`=5, `wr_data`=-2000, `rd_addr`={5,0} in the same cycle → next cycle `rd_data` = {-2000, 0}. A write of 1300 to address 0 → a later read of 0 returns 0.
- **Scoreboard:** reserve 7 → next read of 7 shows busy=1. `wr_en` to 7 with 42 → the following read shows busy=0 and data=42, `sb_err` = 0.
- **Reserve and write same cycle:** reserve 7 and write 7 (7 busy) in one cycle → busy stays 1, data updated, `sb_err` = 0.
- **Errors:** reserve 9 twice → `sb_err`=1 one cycle after the second reserve and stays 1. After `rst`, write 10 unreserved → `sb_err`=1.
- **Parameter sweep:** `NREAD`=4, `DATA_W`=16, `ADDR_W`=3. Random writes/reads against a reference model → all ports match every cycle. Reset mid-run clears all busy bits.
